// File: rtl/grf_wb_arbiter_pkg.sv
// Shared constants, FSM encodings and FIFO entry layout for the GRF write-port arbiter.
package grf_wb_arbiter_pkg;

    localparam int NUM_REGS = 32;
    localparam int ADDR_W   = 5;
    localparam int DATA_W   = 32;
    localparam int PC_W     = 32;
    localparam int ENTRY_W  = ADDR_W + DATA_W + PC_W;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_DRAIN = 2'd1,
        ST_FORCE = 2'd2
    } arb_state_t;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wd;
        logic [PC_W-1:0]   pc;
    } wb_entry_t;

    // One-hot register mask; register 0 never appears in the scoreboard.
    function automatic logic [NUM_REGS-1:0] reg_mask(input logic [ADDR_W-1:0] a);
        reg_mask = '0;
        if (a != '0) reg_mask[a] = 1'b1;
    endfunction

endpackage

// File: rtl/grf_wb_arbiter_fifo.sv
// wb_fifo: DEPTH-entry circular buffer (power-of-two DEPTH) with count, full and empty.
module wb_fifo
    import grf_wb_arbiter_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int W     = ENTRY_W
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic [W-1:0]               push_data,
    input  logic                       pop,
    output logic [W-1:0]               head,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Full pushes and empty pops are dropped; there is no pass-through.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/grf_wb_arbiter.sv
// Shares the GRF write port between the W stage and buffered MDU results, with a busy scoreboard.
// Optional simulation checks are compiled in when GRF_WB_ARB_CHECK_EN is defined.
module grf_wb_arbiter
    import grf_wb_arbiter_pkg::*;
#(
    parameter int DEPTH      = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pipe_we,
    input  logic [4:0]  pipe_addr,
    input  logic [31:0] pipe_wd,
    input  logic [31:0] pipe_pc,
    output logic        pipe_hold,
    input  logic        issue_valid,
    input  logic [4:0]  issue_addr,
    input  logic        mdu_valid,
    output logic        mdu_ready,
    input  logic [4:0]  mdu_addr,
    input  logic [31:0] mdu_wd,
    input  logic [31:0] mdu_pc,
    input  logic [4:0]  rs_addr,
    input  logic [4:0]  rt_addr,
    output logic        stall,
    output logic        grf_we,
    output logic [4:0]  grf_a3,
    output logic [31:0] grf_wd,
    output logic [31:0] grf_pc,
    output logic [1:0]  dbg_state
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int CW    = CNT_W + 1;
    localparam logic [3:0] WAIT_LIMIT = 4'(STARVE_MAX - 1);

    arb_state_t          state_q, state_d;
    logic [3:0]          wait_q, wait_d;
    logic [NUM_REGS-1:0] busy_q, busy_d;

    wb_entry_t           mdu_entry;
    wb_entry_t           head;
    logic [CNT_W-1:0]    count;
    logic                full;
    logic                empty;
    logic                head_valid;
    logic                enq;
    logic                grant_pipe;
    logic                grant_head;
    logic [CW-1:0]       cnt_next;

    // MDU handshake: a result transfers on a cycle where mdu_valid && mdu_ready;
    // mdu_valid may be held across cycles and mdu_ready depends only on FIFO occupancy.
    assign mdu_ready  = !reset && !full;
    assign enq        = mdu_valid && mdu_ready;
    assign head_valid = !empty;
    assign mdu_entry  = '{addr: mdu_addr, wd: mdu_wd, pc: mdu_pc};
    assign cnt_next   = CW'(count) + CW'(enq) - CW'(grant_head);
    assign dbg_state  = state_q;

    wb_fifo #(
        .DEPTH (DEPTH),
        .W     (ENTRY_W)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (enq),
        .push_data (mdu_entry),
        .pop       (grant_head),
        .head      (head),
        .count     (count),
        .full      (full),
        .empty     (empty)
    );

    // A pipe write to r0 is consumed without a grant, so the head may use the port.
    always_comb begin
        grant_pipe = 1'b0;
        grant_head = 1'b0;
        pipe_hold  = 1'b0;
        if (state_q == ST_FORCE) begin
            grant_head = head_valid;
            pipe_hold  = 1'b1;
        end else if (pipe_we && pipe_addr != '0) begin
            grant_pipe = 1'b1;
        end else if (head_valid) begin
            grant_head = 1'b1;
        end
        if (reset) begin
            grant_pipe = 1'b0;
            grant_head = 1'b0;
            pipe_hold  = 1'b0;
        end
    end

    always_comb begin
        grf_we = 1'b0;
        grf_a3 = '0;
        grf_wd = '0;
        grf_pc = '0;
        if (grant_pipe) begin
            grf_we = 1'b1;
            grf_a3 = pipe_addr;
            grf_wd = pipe_wd;
            grf_pc = pipe_pc;
        end else if (grant_head) begin
            grf_we = 1'b1;
            grf_a3 = head.addr;
            grf_wd = head.wd;
            grf_pc = head.pc;
        end
    end

    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        case (state_q)
            ST_EMPTY: begin
                wait_d = '0;
                if (enq) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (!head_valid) begin
                    state_d = ST_EMPTY;
                    wait_d  = '0;
                end else if (grant_head) begin
                    wait_d = '0;
                    if (cnt_next == '0) state_d = ST_EMPTY;
                end else begin
                    wait_d = wait_q + 4'd1;
                    if (wait_q == WAIT_LIMIT) state_d = ST_FORCE;
                end
            end
            ST_FORCE: begin
                wait_d  = '0;
                state_d = (cnt_next != '0) ? ST_DRAIN : ST_EMPTY;
            end
            default: begin
                state_d = ST_EMPTY;
                wait_d  = '0;
            end
        endcase
    end

    // Issue set is applied after the grant clear so a same-register set wins.
    always_comb begin
        busy_d = busy_q;
        if (grant_head) busy_d = busy_d & ~reg_mask(head.addr);
        if (issue_valid) busy_d = busy_d | reg_mask(issue_addr);
    end

    assign stall = !reset && (busy_q[rs_addr] || busy_q[rt_addr]);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_EMPTY;
            wait_q  <= '0;
            busy_q  <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            busy_q  <= busy_d;
        end
    end

`ifdef GRF_WB_ARB_CHECK_EN
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (pipe_we && pipe_addr != '0 && busy_q[pipe_addr])
                $display("grf_wb_arbiter error: pipe write to busy r%0d pc=%h", pipe_addr, pipe_pc);
            if (issue_valid && issue_addr != '0 && busy_q[issue_addr])
                $display("grf_wb_arbiter error: issue to busy r%0d", issue_addr);
            if (mdu_valid && !mdu_ready)
                $display("grf_wb_arbiter error: mdu_valid while not ready pc=%h", mdu_pc);
            if (grant_head && head.addr != '0 && !busy_q[head.addr])
                $display("grf_wb_arbiter error: granted head r%0d not busy pc=%h", head.addr, head.pc);
        end
    end
`endif

endmodule

// File: tb/tb_grf_wb_arbiter.sv
// Directed scoreboard bench for grf_wb_arbiter (DEPTH=2, STARVE_MAX=4).
module tb_grf_wb_arbiter;

    logic        clk;
    logic        reset;
    logic        pipe_we;
    logic [4:0]  pipe_addr;
    logic [31:0] pipe_wd;
    logic [31:0] pipe_pc;
    logic        pipe_hold;
    logic        issue_valid;
    logic [4:0]  issue_addr;
    logic        mdu_valid;
    logic        mdu_ready;
    logic [4:0]  mdu_addr;
    logic [31:0] mdu_wd;
    logic [31:0] mdu_pc;
    logic [4:0]  rs_addr;
    logic [4:0]  rt_addr;
    logic        stall;
    logic        grf_we;
    logic [4:0]  grf_a3;
    logic [31:0] grf_wd;
    logic [31:0] grf_pc;
    logic [1:0]  dbg_state;

    int n_checks = 0;
    int n_fail   = 0;
    logic [68:0] exp_q[$];

    grf_wb_arbiter #(
        .DEPTH      (2),
        .STARVE_MAX (4)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .pipe_we     (pipe_we),
        .pipe_addr   (pipe_addr),
        .pipe_wd     (pipe_wd),
        .pipe_pc     (pipe_pc),
        .pipe_hold   (pipe_hold),
        .issue_valid (issue_valid),
        .issue_addr  (issue_addr),
        .mdu_valid   (mdu_valid),
        .mdu_ready   (mdu_ready),
        .mdu_addr    (mdu_addr),
        .mdu_wd      (mdu_wd),
        .mdu_pc      (mdu_pc),
        .rs_addr     (rs_addr),
        .rt_addr     (rt_addr),
        .stall       (stall),
        .grf_we      (grf_we),
        .grf_a3      (grf_a3),
        .grf_wd      (grf_wd),
        .grf_pc      (grf_pc),
        .dbg_state   (dbg_state)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #3;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Driver tasks
    task automatic drive_idle();
        pipe_we     = 1'b0;
        pipe_addr   = '0;
        pipe_wd     = '0;
        pipe_pc     = '0;
        issue_valid = 1'b0;
        issue_addr  = '0;
        mdu_valid   = 1'b0;
        mdu_addr    = '0;
        mdu_wd      = '0;
        mdu_pc      = '0;
    endtask

    task automatic drive_pipe(input logic [4:0] a, input logic [31:0] wd, input logic [31:0] pc);
        pipe_we   = 1'b1;
        pipe_addr = a;
        pipe_wd   = wd;
        pipe_pc   = pc;
    endtask

    task automatic drive_mdu(input logic [4:0] a, input logic [31:0] wd, input logic [31:0] pc);
        mdu_valid = 1'b1;
        mdu_addr  = a;
        mdu_wd    = wd;
        mdu_pc    = pc;
    endtask

    task automatic drive_issue(input logic [4:0] a);
        issue_valid = 1'b1;
        issue_addr  = a;
    endtask

    task automatic expect_write(input logic [4:0] a, input logic [31:0] wd, input logic [31:0] pc);
        exp_q.push_back({a, wd, pc});
    endtask

    // Scoreboard monitor: every register-file write must match the next expected entry.
    always @(negedge clk) begin
        if (!reset && grf_we === 1'b1) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_write: got a3=%0d wd=%h pc=%h, required no write", grf_a3, grf_wd, grf_pc);
            end else begin
                logic [68:0] e;
                e = exp_q.pop_front();
                if ({grf_a3, grf_wd, grf_pc} !== e) begin
                    n_fail++;
                    $display("FAIL grf_write: got a3=%0d wd=%h pc=%h, required a3=%0d wd=%h pc=%h",
                             grf_a3, grf_wd, grf_pc, e[68:64], e[63:32], e[31:0]);
                end
            end
        end
    end

    int idx;

    initial begin
        reset   = 1'b1;
        rs_addr = '0;
        rt_addr = '0;
        drive_idle();
        drive_pipe(5'd5, 32'h55, 32'h80);
        drive_mdu(5'd8, 32'h66, 32'h84);
        #3;
        check("rst_grf_we", grf_we, 0);
        check("rst_mdu_ready", mdu_ready, 0);
        check("rst_pipe_hold", pipe_hold, 0);
        check("rst_stall", stall, 0);
        check("rst_grf_a3", grf_a3, 0);
        check("rst_grf_wd", grf_wd, 0);
        check("rst_grf_pc", grf_pc, 0);
        tick();
        tick();
        reset = 1'b0;
        drive_idle();
        settle();
        check("post_rst_state", dbg_state, 0);
        check("post_rst_ready", mdu_ready, 1);

        // Pipe-only write, combinational in the same cycle
        tick();
        drive_idle();
        drive_pipe(5'd5, 32'h1234, 32'h100);
        expect_write(5'd5, 32'h1234, 32'h100);
        settle();
        check("pipe_hold", pipe_hold, 0);
        check("pipe_grf_we", grf_we, 1);

        // Pipe write to r0 is consumed without a write
        tick();
        drive_idle();
        drive_pipe(5'd0, 32'hDEAD, 32'h104);
        settle();
        check("r0_grf_we", grf_we, 0);
        check("r0_hold", pipe_hold, 0);

        // MDU idle drain
        tick();
        drive_idle();
        drive_issue(5'd8);
        rs_addr = 5'd8;
        settle();
        check("drain_stall_issue", stall, 0);
        tick();
        drive_idle();
        settle();
        check("drain_stall_busy", stall, 1);
        tick();
        drive_idle();
        drive_mdu(5'd8, 32'hABCD, 32'h200);
        settle();
        check("drain_ready", mdu_ready, 1);
        check("drain_no_bypass", grf_we, 0);
        tick();
        drive_idle();
        expect_write(5'd8, 32'hABCD, 32'h200);
        settle();
        check("drain_state", dbg_state, 1);
        check("drain_stall_grant", stall, 1);
        tick();
        drive_idle();
        settle();
        check("drain_stall_clear", stall, 0);
        check("drain_state_empty", dbg_state, 0);

        // Starvation: pipe writes every cycle while r10's result waits
        tick();
        drive_idle();
        drive_issue(5'd10);
        rs_addr = 5'd10;
        for (int k = 0; k < 7; k++) begin
            tick();
            drive_idle();
            if (k == 0) drive_mdu(5'd10, 32'hBEEF, 32'h300);
            idx = (k <= 5) ? k : 5;
            drive_pipe(5'd1, 32'h1000 + 32'(idx), 32'h400 + 32'(4 * idx));
            if (k == 5) expect_write(5'd10, 32'hBEEF, 32'h300);
            else        expect_write(5'd1, 32'h1000 + 32'(idx), 32'h400 + 32'(4 * idx));
            settle();
            check("starve_hold", pipe_hold, (k == 5) ? 1 : 0);
            check("starve_stall", stall, (k <= 5) ? 1 : 0);
            check("starve_state", dbg_state, (k == 0) ? 0 : (k <= 4) ? 1 : (k == 5) ? 2 : 0);
        end

        // FIFO full: two results while the pipe stays busy
        tick();
        drive_idle();
        drive_issue(5'd11);
        rs_addr = 5'd11;
        rt_addr = 5'd12;
        tick();
        drive_idle();
        drive_issue(5'd12);
        for (int d = 0; d < 8; d++) begin
            tick();
            drive_idle();
            if (d == 0) drive_mdu(5'd11, 32'h1111, 32'h700);
            if (d == 1) drive_mdu(5'd12, 32'h2222, 32'h704);
            idx = (d <= 5) ? d : 5;
            if (d <= 6) drive_pipe(5'd2, 32'h2000 + 32'(idx), 32'h800 + 32'(4 * idx));
            if (d == 5)      expect_write(5'd11, 32'h1111, 32'h700);
            else if (d == 7) expect_write(5'd12, 32'h2222, 32'h704);
            else             expect_write(5'd2, 32'h2000 + 32'(idx), 32'h800 + 32'(4 * idx));
            settle();
            check("full_ready", mdu_ready, (d < 2 || d >= 6) ? 1 : 0);
            check("full_hold", pipe_hold, (d == 5) ? 1 : 0);
            check("full_stall", stall, 1);
        end
        tick();
        drive_idle();
        settle();
        check("full_stall_clear", stall, 0);

        // Same-register set and clear in one cycle
        rs_addr = 5'd3;
        rt_addr = 5'd0;
        tick();
        drive_idle();
        drive_issue(5'd3);
        tick();
        drive_idle();
        drive_mdu(5'd3, 32'h3333, 32'h500);
        tick();
        drive_idle();
        drive_issue(5'd3);
        expect_write(5'd3, 32'h3333, 32'h500);
        settle();
        check("setclr_grant", grf_we, 1);
        tick();
        drive_idle();
        drive_mdu(5'd3, 32'h3334, 32'h504);
        settle();
        check("setclr_busy_kept", stall, 1);
        tick();
        drive_idle();
        expect_write(5'd3, 32'h3334, 32'h504);
        settle();
        check("setclr_stall_grant", stall, 1);
        tick();
        drive_idle();
        settle();
        check("setclr_stall_clear", stall, 0);

        // Reset with two FIFO entries and busy r8/r9
        rs_addr = 5'd8;
        rt_addr = 5'd9;
        tick();
        drive_idle();
        drive_issue(5'd8);
        tick();
        drive_idle();
        drive_issue(5'd9);
        tick();
        drive_idle();
        drive_mdu(5'd8, 32'h8888, 32'h600);
        drive_pipe(5'd2, 32'h3000, 32'h900);
        expect_write(5'd2, 32'h3000, 32'h900);
        tick();
        drive_idle();
        drive_mdu(5'd9, 32'h9990, 32'h604);
        drive_pipe(5'd2, 32'h3001, 32'h904);
        expect_write(5'd2, 32'h3001, 32'h904);
        settle();
        check("mid_ready", mdu_ready, 1);
        check("mid_stall", stall, 1);
        tick();
        reset = 1'b1;
        drive_pipe(5'd2, 32'h3002, 32'h908);
        drive_mdu(5'd9, 32'h9990, 32'h604);
        settle();
        check("mid_rst_grf_we", grf_we, 0);
        check("mid_rst_ready", mdu_ready, 0);
        check("mid_rst_stall", stall, 0);
        check("mid_rst_hold", pipe_hold, 0);
        check("mid_rst_a3", grf_a3, 0);
        tick();
        tick();
        reset = 1'b0;
        drive_idle();
        settle();
        check("post_mid_stall", stall, 0);
        check("post_mid_ready", mdu_ready, 1);
        check("post_mid_state", dbg_state, 0);
        check("post_mid_grf_we", grf_we, 0);
        tick();
        drive_idle();
        drive_mdu(5'd9, 32'h9999, 32'h608);
        settle();
        check("post_mid_no_stale", grf_we, 0);
        tick();
        drive_idle();
        expect_write(5'd9, 32'h9999, 32'h608);
        settle();
        check("post_mid_grant", grf_we, 1);

        tick();
        drive_idle();
        tick();
        settle();
        check("exp_q_empty", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/grf_wb_arbiter.md
# grf_wb_arbiter

Write-port arbiter and scoreboard for the 32x32 general register file. Shares the file's single write port between the in-order pipeline writeback stage and the multi-cycle multiply/divide unit (MDU). MDU results wait in a small FIFO; a per-register busy scoreboard stalls dependent instructions. Sits between the W stage / MDU and the register file's write inputs (write enable, A3, write data, PC).

## Interface
- DEPTH, 2: MDU result FIFO entries (power of two, ≥2)
- STARVE_MAX, 4: cycles a FIFO head may be denied before a forced drain (1..15)

Ports:
- clk  in  1  clock; all state updates on posedge
- reset  in  1  asynchronous, active-high
- pipe_we  in  1  W-stage write request
- pipe_addr  in  5  W-stage destination register
- pipe_wd  in  32  W-stage write data
- pipe_pc  in  32  W-stage instruction PC
- pipe_hold  out  1  W-stage write not taken this cycle; the W stage holds and retries
- issue_valid  in  1  MDU operation issued this cycle
- issue_addr  in  5  destination of the issued MDU op
- mdu_valid  in  1  MDU result valid
- mdu_ready  out  1  FIFO can accept a result
- mdu_addr  in  5  result destination
- mdu_wd  in  32  result data
- mdu_pc  in  32  PC of the originating instruction
- rs_addr, rt_addr  in  5 each  D-stage source registers
- stall  out  1  a D-stage source is busy
- grf_we  out  1  register-file write enable
- grf_a3  out  5  register-file write address
- grf_wd  out  32  register-file write data
- grf_pc  out  32  PC forwarded to the register file

## Operation
- FIFO: circular buffer of {addr, wd, pc}, with read/write pointers that wrap modulo DEPTH and a count. Enqueue when mdu_valid && mdu_ready. mdu_ready = (count < DEPTH); no pass-through when full.
- Scoreboard: busy[31:1]; register 0 is never busy. Set busy[issue_addr] on issue_valid when issue_addr != 0. Clear busy[head.addr] when the head is granted. Set and clear of the same register in one cycle: set wins.
- stall = busy[rs_addr] | busy[rt_addr]. Combinational.
- Grant: grf_* is driven by exactly one source, or grf_we=0.
  - FORCE: grant the FIFO head; pipe_hold=1.
  - Otherwise, pipe_we=1 with pipe_addr != 0: grant the pipe; pipe_hold=0.
  - Otherwise, FIFO non-empty: grant the head.
  - Otherwise: grf_we=0.
  - A pipe request to address 0 is consumed with grf_we=0.
- FSM:
  - EMPTY: count==0.
  - DRAIN: head present. wait_cnt increments each cycle the head is denied; reset to 0 on grant.
  - DRAIN→FORCE when wait_cnt == STARVE_MAX−1 and the head is denied.
  - FORCE lasts exactly one cycle, then goes to DRAIN if count after dequeue > 0, else EMPTY.
  - EMPTY→DRAIN on enqueue.
- Reset (async):
  - Clears the FIFO, busy, wait_cnt and pointers; state EMPTY.
  - While reset is high: grf_we=0, mdu_ready=0, stall=0, pipe_hold=0, grf_a3=0, grf_wd=0, grf_pc=0.
  - Any in-flight MDU result is discarded.

## Timing
- Pipe write: grf_* valid in the same cycle (combinational); the register file commits at the next posedge.
- MDU write: enqueue at posedge N. Earliest grant is cycle N+1 (no same-cycle bypass), with commit at the N+2 posedge.
- busy bit: rises the cycle after issue_valid and falls the cycle after the grant, so stall is deasserted the cycle after the write commits.
- Worst-case drain latency per head: STARVE_MAX+1 cycles.
- Simultaneous enqueue and dequeue: count is unchanged and both pointers advance.

## Configuration
- GRF_WB_ARB_CHECK_EN defined: simulation-only checks that $display an error with the PC:
  - pipe_we to a busy register
  - issue_valid to an already-busy register
  - mdu_valid while !mdu_ready
  - a granted head whose busy bit is clear
- GRF_WB_ARB_CHECK_EN undefined: no check logic, identical RTL behaviour.

## Structure
- Shared package/header: the register-count constant (32), the address width (5), the FSM state encodings (EMPTY, DRAIN, FORCE), and the FIFO entry field widths.
- One sub-module: wb_fifo, a parameterized DEPTH circular buffer with count, full and empty. The scoreboard and FSM stay in the top module.

## Test plan
- Pipe only: pipe_we=1, addr=5, wd=0x1234 → grf_we=1, grf_a3=5, grf_wd=0x1234 in the same cycle; pipe_hold=0.
- MDU idle drain:
  - issue addr=8 → stall=1 for rs_addr=8 from the next cycle.
  - Result 0xABCD enqueued at cycle N → grant at N+1, busy[8] clear at N+2, stall=0.
- Starvation (STARVE_MAX=4): MDU result pending with pipe_we=1 every cycle → 4 pipe grants, then 1 cycle with pipe_hold=1 and grf_a3=MDU addr, then pipe resumes.
- FIFO full (DEPTH=2): two results while the pipe is continuously busy → mdu_ready=0 until the first forced drain, then 1.
- Same-register set/clear: issue to reg 3 in the same cycle as reg 3's buffered write is granted → busy[3] remains 1.
- Reset mid-operation: assert reset with 2 FIFO entries and busy[8,9] set → grf_we=0 and mdu_ready=0 immediately; after release, count=0, busy=0, stall=0.
